fsm_seq_ctrl: RTL
=================

Name: fsm_seq_ctrl

Overview:
Controller that sequences the team's 4-state FSM cycle (S0->S1->S2->S3->S0) with a programmable dwell time per state.
- Adds start/stop/pause control, a runtime configuration port for the dwell registers, and a wrap pulse once per completed cycle.
- Sits above the 4-state FSM; `state_out` drives the same downstream logic the free-running FSM drives today.

Parameters:
- CNT_W, 8, width of the dwell registers and the dwell counter.
- DWELL0, 4, reset dwell for S0, in cycles.
- DWELL1, 4, reset dwell for S1, in cycles.
- DWELL2, 4, reset dwell for S2, in cycles.
- DWELL3, 4, reset dwell for S3, in cycles.

Ports:
- clk  input  1  single clock, rising edge.
- reset  input  1  asynchronous, active-low reset (0 = reset asserted).
- start  input  1  begin sequencing from IDLE, or resume from HOLD.
- stop  input  1  abort; return to IDLE.
- pause  input  1  level; while high in RUN, freeze the sequence.
- cfg_we  input  1  write strobe for a dwell register.
- cfg_sel  input  2  selects the dwell register to write (0..3).
- cfg_dwell  input  CNT_W  dwell value to write.
- state_out  output  2  current sequence state, binary (S0=00 .. S3=11).
- busy  output  1  high in RUN and HOLD.
- wrap_pulse  output  1  one-cycle pulse on the S3->S0 transition.
- cycle_cnt  output  8  count of completed cycles; wraps 255->0.

Behaviour:
Reset (reset=0, asynchronous):
- ctrl=IDLE, state_out=00, busy=0, wrap_pulse=0, cycle_cnt=0.
- Dwell counter=0; dwell registers=DWELL0..3.

Control FSM, one transition per clock edge:
- IDLE: start=1 -> RUN; load counter with dwell[S0]; state_out stays 00.
- RUN:
  - stop=1 -> IDLE.
  - else pause=1 -> HOLD.
  - else counter decrements by 1.
  - When counter==1 (or the loaded dwell was 0), advance state_out at this edge and reload counter with dwell[next state].
- HOLD:
  - stop=1 -> IDLE.
  - else start=1 and pause=0 -> RUN.
  - Counter and state_out frozen.
- Entering IDLE from any state: state_out=00, counter=0, cycle_cnt retained.

Dwell and timing:
- A dwell of N means state_out holds each state for exactly N RUN cycles.
- Dwell 0 is treated as 1.
- First state change occurs dwell[S0] cycles after the start edge.

Priority and simultaneous events:
- stop > pause > start.
- start while RUN is ignored.
- start+stop in the same cycle -> IDLE.

Wrap:
- On S3->S0: wrap_pulse=1 for one cycle; cycle_cnt increments in the same edge.

Configuration:
- cfg_we is honoured in any ctrl state.
- A write to the dwell of the currently active state does not change the running counter; it takes effect at the next reload.
- A write in the same cycle as a reload of that register: the reload uses the old value.

Outputs:
- All outputs are registered; no combinational input->output paths.

Optional Feature:
- FSM_SEQ_ONESHOT_EN defined: after S3's dwell expires, ctrl goes to IDLE, state_out=00, and wrap_pulse and cycle_cnt update as normal; a new start is required to run again.
- Undefined: the sequence wraps continuously S3->S0 while in RUN.

Decomposition:
- Shared package fsm_seq_pkg holds:
  - ctrl encodings: IDLE=2'd0, RUN=2'd1, HOLD=2'd2.
  - state encodings S0..S3 = 2'd0..2'd3.
  - the default dwell constants.
- One sub-module, fsm_dwell_timer, holds:
  - the loadable down-counter, CNT_W wide;
  - ports load, load_val, en, expire;
  - expire is asserted when en and count<=1.

Test Plan:
1. Defaults; deassert reset, start pulse at t0 -> state_out 00,01,10,11 each held 4 cycles; wrap_pulse at cycle 16; cycle_cnt=1.
2. Write cfg_sel=2, cfg_dwell=1 and cfg_sel=1, cfg_dwell=0 before start -> S1 and S2 each last 1 cycle; S0 and S3 last 4.
3. pause=1 for 5 cycles during S1 (2 cycles remaining) -> state_out frozen at 01, busy=1; start after pause drops -> S1 lasts 2 more cycles, then 10.
4. Same-cycle start+stop while RUN in S2 -> next cycle IDLE, state_out=00, busy=0, cycle_cnt unchanged.
5. reset=0 asserted asynchronously mid-S3 (between clock edges) -> outputs clear immediately; dwell registers return to 4.
6. With FSM_SEQ_ONESHOT_EN defined: one start -> a single S0..S3 pass, wrap_pulse once, then IDLE with busy=0; a second start repeats the pass.

Source files
------------

// File: rtl/fsm_seq_pkg.sv
// rtl/fsm_seq_pkg.sv - shared encodings and defaults for the 4-state sequence controller
//
// Purpose: control-FSM and sequence-state encodings, default dwell values,
//          and the S0->S1->S2->S3->S0 successor function.
// Ports:   none (package).

package fsm_seq_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        HOLD = 2'd2
    } ctrl_e;

    typedef enum logic [1:0] {
        S0 = 2'd0,
        S1 = 2'd1,
        S2 = 2'd2,
        S3 = 2'd3
    } seq_state_e;

    localparam int DEF_DWELL0 = 4;
    localparam int DEF_DWELL1 = 4;
    localparam int DEF_DWELL2 = 4;
    localparam int DEF_DWELL3 = 4;

    function automatic seq_state_e next_state(input seq_state_e s);
        case (s)
            S0:      next_state = S1;
            S1:      next_state = S2;
            S2:      next_state = S3;
            default: next_state = S0;
        endcase
    endfunction

endpackage

// File: rtl/fsm_dwell_timer.sv
// rtl/fsm_dwell_timer.sv - loadable down-counter that times the dwell of one sequence state
//
// Purpose: counts RUN cycles spent in the current state. A loaded value of 0
//          behaves like 1, because expire fires whenever count <= 1.
// Ports:
//   clk      - rising-edge clock
//   reset    - asynchronous active-low reset (count clears to 0)
//   load     - load load_val this edge (takes priority over en)
//   load_val - dwell value to load
//   en       - count down this edge
//   expire   - en && count <= 1 (combinational; last cycle of the dwell)

module fsm_dwell_timer #(
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             load,
    input  logic [CNT_W-1:0] load_val,
    input  logic             en,
    output logic             expire
);

    logic [CNT_W-1:0] count;

    assign expire = en && (count <= CNT_W'(1));

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            count <= '0;
        end else if (load) begin
            count <= load_val;
        end else if (en && (count != '0)) begin
            count <= count - CNT_W'(1);
        end
    end

endmodule

// File: rtl/fsm_seq_ctrl.sv
// rtl/fsm_seq_ctrl.sv - start/stop/pause sequencer for the 4-state FSM with programmable dwell
//
// Purpose: steps state_out through S0..S3. Each state is held for its dwell
//          register's value in RUN cycles, where 0 counts as 1. The sequence
//          wraps continuously while in RUN.
//          Optional build macro FSM_SEQ_ONESHOT_EN: a single pass is made,
//          then the controller returns to IDLE after S3.
// Ports:
//   clk        - rising-edge clock
//   reset      - asynchronous active-low reset
//   start      - leave IDLE, or resume from HOLD (when pause is low)
//   stop       - abort to IDLE (highest priority)
//   pause      - level; freezes the sequence while in RUN
//   cfg_we     - dwell register write strobe (honoured in any ctrl state)
//   cfg_sel    - dwell register index 0..3
//   cfg_dwell  - dwell value to write
//   state_out  - current sequence state (registered)
//   busy       - high in RUN and HOLD (registered)
//   wrap_pulse - one-cycle pulse after each S3->S0 transition (registered)
//   cycle_cnt  - completed-cycle counter, wraps 255->0 (registered)

module fsm_seq_ctrl
    import fsm_seq_pkg::*;
#(
    parameter int CNT_W  = 8,
    parameter int DWELL0 = DEF_DWELL0,
    parameter int DWELL1 = DEF_DWELL1,
    parameter int DWELL2 = DEF_DWELL2,
    parameter int DWELL3 = DEF_DWELL3
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic             stop,
    input  logic             pause,
    input  logic             cfg_we,
    input  logic [1:0]       cfg_sel,
    input  logic [CNT_W-1:0] cfg_dwell,
    output logic [1:0]       state_out,
    output logic             busy,
    output logic             wrap_pulse,
    output logic [7:0]       cycle_cnt
);

    ctrl_e            ctrl_q, ctrl_d;
    seq_state_e       state_q, state_d;
    logic [CNT_W-1:0] dwell_q [4];
    logic             t_load;
    logic [CNT_W-1:0] t_val;
    logic             t_en;
    logic             t_expire;
    logic             wrap_d;

    // The timer only advances on plain RUN cycles. A stop or pause edge
    // leaves the counter untouched (stop reloads it with 0 below).
    assign t_en = (ctrl_q == RUN) && !stop && !pause;

    fsm_dwell_timer #(
        .CNT_W    (CNT_W)
    ) u_timer (
        .clk      (clk),
        .reset    (reset),
        .load     (t_load),
        .load_val (t_val),
        .en       (t_en),
        .expire   (t_expire)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            ctrl_q  <= IDLE;
            state_q <= S0;
        end else begin
            ctrl_q  <= ctrl_d;
            state_q <= state_d;
        end
    end

    // Reloads read dwell_q before this edge's cfg write lands, so a write
    // in the same cycle as a reload of that register uses the old value.
    always_comb begin
        ctrl_d  = ctrl_q;
        state_d = state_q;
        t_load  = 1'b0;
        t_val   = '0;
        wrap_d  = 1'b0;
        case (ctrl_q)
            IDLE: begin
                if (start && !stop) begin
                    ctrl_d  = RUN;
                    state_d = S0;
                    t_load  = 1'b1;
                    t_val   = dwell_q[S0];
                end
            end
            RUN: begin
                if (stop) begin
                    ctrl_d  = IDLE;
                    state_d = S0;
                    t_load  = 1'b1;
                end else if (pause) begin
                    ctrl_d = HOLD;
                end else if (t_expire) begin
                    state_d = next_state(state_q);
                    t_load  = 1'b1;
                    t_val   = dwell_q[state_d];
                    if (state_q == S3) begin
                        wrap_d = 1'b1;
`ifdef FSM_SEQ_ONESHOT_EN
                        ctrl_d = IDLE;
                        t_val  = '0;
`endif
                    end
                end
            end
            HOLD: begin
                if (stop) begin
                    ctrl_d  = IDLE;
                    state_d = S0;
                    t_load  = 1'b1;
                end else if (start && !pause) begin
                    ctrl_d = RUN;
                end
            end
            default: begin
                ctrl_d  = IDLE;
                state_d = S0;
                t_load  = 1'b1;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            busy       <= 1'b0;
            wrap_pulse <= 1'b0;
            cycle_cnt  <= 8'd0;
        end else begin
            busy       <= (ctrl_d != IDLE);
            wrap_pulse <= wrap_d;
            if (wrap_d) begin
                cycle_cnt <= cycle_cnt + 8'd1;
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            dwell_q[0] <= CNT_W'(DWELL0);
            dwell_q[1] <= CNT_W'(DWELL1);
            dwell_q[2] <= CNT_W'(DWELL2);
            dwell_q[3] <= CNT_W'(DWELL3);
        end else if (cfg_we) begin
            dwell_q[cfg_sel] <= cfg_dwell;
        end
    end

    assign state_out = state_q;

endmodule
